// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pid_pkg
// Summary  : Shared definitions for the PID controller and its PWM output
//            stage: state encodings, duty width, period length and the
//            slew-limited duty update helper.
// Revision : 1.0 - initial release
// ============================================================================
package pid_pkg;

    // Duty word width, shared with pid_controller's control_out.
    localparam int DUTY_W     = 8;

    // Last count value of a PWM period; a period is PERIOD_MAX+1 steps.
    localparam int PERIOD_MAX = 254;

    // PWM generator operating states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pwm_state_t;

    // Move 'current' toward 'target' by at most 'max_step' LSBs.
    // A max_step of zero means no limit. The difference is formed in
    // DUTY_W+1 bits so the sign survives the full 0..255 span, and the
    // step is only taken when |diff| exceeds max_step, so the add or
    // subtract can never leave the 0..255 range.
    function automatic logic [DUTY_W-1:0] slew_limit(
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] current,
        input logic [DUTY_W-1:0] max_step
    );
        logic [DUTY_W:0] w_diff;
        logic [DUTY_W:0] w_mag;
        w_diff = {1'b0, target} - {1'b0, current};
        w_mag  = w_diff[DUTY_W] ? ((~w_diff) + {{DUTY_W{1'b0}}, 1'b1}) : w_diff;
        if ((max_step == '0) || (w_mag <= {1'b0, max_step})) begin
            return target;
        end else if (w_diff[DUTY_W]) begin
            return current - max_step;
        end else begin
            return current + max_step;
        end
    endfunction

endpackage : pid_pkg
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Summary  : Clock-enable generator for the PWM period counter. Counts
//            0..PRESCALE-1 and flags the last count with 'tick'. 'clear'
//            holds the counter at zero so a new period always starts with
//            a full-length first step.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler
    import pid_pkg::*;
#(
    parameter int PRESCALE = 4      // clk cycles per count step, 1..65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // Terminal count; with PRESCALE=1 this is zero and tick is permanently
    // high, so the period counter advances every clock.
    localparam logic [15:0] c_PSC_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_psc;

    // Tick is decoded from the counter value, so it is high for exactly
    // one clock out of every PRESCALE while the counter is free-running.
    assign tick = (r_psc == c_PSC_LAST);

    // Prescale counter: held at zero while cleared, wraps after the tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_psc <= '0;
        end else if (tick) begin
            r_psc <= '0;
        end else begin
            r_psc <= r_psc + 16'd1;
        end
    end

endmodule : pwm_prescaler
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Summary  : PWM output stage of the PID loop. Converts an 8-bit duty
//            command into a 255-step PWM waveform. Duty commands land in a
//            shadow register and are applied (optionally slew limited) only
//            at period boundaries. A one-cycle period_start strobe marks
//            every period and serves as the PID sample tick. A latched fault
//            input forces the output low until explicitly released.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_generator
    import pid_pkg::*;
#(
    parameter int PRESCALE = 4,     // clk cycles per PWM count step
    parameter int SLEW     = 0      // max duty change per period, 0 = none
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    input  logic              fault,
    input  logic              fault_clr,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_applied,
    output logic              faulted
);

    // Any slew at or above the full duty span behaves as unlimited, so the
    // parameter is clipped to the duty width once here.
    localparam logic [DUTY_W-1:0] c_SLEW =
        (SLEW > 255) ? {DUTY_W{1'b1}} : DUTY_W'(SLEW);
    localparam logic [DUTY_W-1:0] c_PERIOD_LAST = DUTY_W'(PERIOD_MAX);

    pwm_state_t        r_state;
    pwm_state_t        w_state_next;
    logic              w_enter_run;   // IDLE -> RUN this cycle
    logic              w_run_hold;    // staying in RUN this cycle
    logic              w_tick;        // prescaler terminal count
    logic              w_wrap;        // last step of the period ends now
    logic              w_psc_clear;
    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_shadow;

    // ------------------------------------------------------------------
    // Prescaler: only free-runs while the block stays in RUN, so entering
    // RUN or leaving it always leaves the prescaler at zero.
    // ------------------------------------------------------------------
    assign w_psc_clear = !w_run_hold;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (w_psc_clear),
        .tick  (w_tick)
    );

    // A period boundary inside RUN; never taken when fault or en=0 wins.
    assign w_wrap = w_run_hold && w_tick && (r_cnt == c_PERIOD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode. Fault has priority over en and over the period
    // wrap; in FAULT the release needs fault_clr with fault already gone.
    always_comb begin
        w_state_next = r_state;
        w_enter_run  = 1'b0;
        w_run_hold   = 1'b0;
        case (r_state)
            IDLE: begin
                if (fault) begin
                    w_state_next = FAULT;
                end else if (en) begin
                    w_state_next = RUN;
                    w_enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (fault) begin
                    w_state_next = FAULT;
                end else if (!en) begin
                    w_state_next = IDLE;
                end else begin
                    w_run_hold   = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr && !fault) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Period counter: 0..PERIOD_MAX, one step per prescaler tick, and
    // forced back to zero whenever the block is not running.
    always_ff @(posedge clk) begin
        if (rst || !w_run_hold) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + {{(DUTY_W-1){1'b0}}, 1'b1};
        end
    end

    // Shadow register: loaded in every state. A load coincident with a
    // boundary is seen only at the following boundary, because the
    // boundary logic below reads the register's current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (duty_valid) begin
            r_shadow <= duty_in;
        end
    end

    // Applied duty: updated only at period boundaries (entry into RUN
    // slews from zero), cleared whenever the block leaves RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_applied <= '0;
        end else if (w_enter_run) begin
            duty_applied <= slew_limit(r_shadow, '0, c_SLEW);
        end else if (w_wrap) begin
            duty_applied <= slew_limit(r_shadow, duty_applied, c_SLEW);
        end else if (!w_run_hold) begin
            duty_applied <= '0;
        end
    end

    // Registered outputs. The compare uses the duty in force during the
    // current step, so at a wrap the last step of the old period still
    // compares against the old duty and duty 0/255 never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            faulted      <= 1'b0;
        end else begin
            pwm_out      <= w_run_hold && (r_cnt < duty_applied);
            period_start <= w_enter_run || w_wrap;
            faulted      <= (w_state_next == FAULT);
        end
    end

endmodule : pwm_generator
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_generator
// Summary  : Self-checking bench for pwm_generator. Two instances (fast,
//            unlimited slew and slower, slew-limited) share one stimulus
//            stream; a period-position reference model predicts every
//            output on every cycle, alongside directed scenario checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_generator;

    localparam int P_A = 1;
    localparam int S_A = 0;
    localparam int P_B = 3;
    localparam int S_B = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    // Reference view: mode, cycle position within the period, duties and
    // the expected registered outputs after the most recent edge.
    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] t;
        logic [7:0]  duty;
        logic [7:0]  shadow;
        logic        pwm;
        logic        ps;
        logic        flt;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       duty_valid = 1'b0;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic [7:0] duty_in = 8'd0;

    logic       a_pwm, a_ps, a_flt;
    logic [7:0] a_duty;
    logic       b_pwm, b_ps, b_flt;
    logic [7:0] b_duty;

    mdl_t ma = '0;
    mdl_t mb = '0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_cyc = 0;
    int   hi;
    int   lo;
    int   nps;
    int   slew_exp [7] = '{16, 32, 48, 64, 80, 96, 100};

    always #5 clk = ~clk;

    pwm_generator #(.PRESCALE(P_A), .SLEW(S_A)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
        .duty_valid(duty_valid), .fault(fault), .fault_clr(fault_clr),
        .pwm_out(a_pwm), .period_start(a_ps), .duty_applied(a_duty),
        .faulted(a_flt)
    );

    pwm_generator #(.PRESCALE(P_B), .SLEW(S_B)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
        .duty_valid(duty_valid), .fault(fault), .fault_clr(fault_clr),
        .pwm_out(b_pwm), .period_start(b_ps), .duty_applied(b_duty),
        .faulted(b_flt)
    );

    // Move toward the target by at most s per period (s=0: jump).
    function automatic int slew_to(input int tgt, input int cur, input int s);
        if (s == 0) return tgt;
        if (tgt > cur) return ((tgt - cur) > s) ? cur + s : tgt;
        return ((cur - tgt) > s) ? cur - s : tgt;
    endfunction

    // Predict the state after the next edge from the current inputs.
    function automatic mdl_t mstep(input mdl_t m, input int p, input int s);
        mdl_t n;
        int   t;
        int   d;
        n     = m;
        n.ps  = 1'b0;
        n.pwm = 1'b0;
        if (rst) begin
            n = '0;
            return n;
        end
        case (int'(m.mode))
            M_IDLE: begin
                if (fault) begin
                    n.mode = 2'(M_FAULT);
                end else if (en) begin
                    n.mode = 2'(M_RUN);
                    n.t    = 16'd0;
                    n.duty = 8'(slew_to(int'(m.shadow), 0, s));
                    n.ps   = 1'b1;
                end
            end
            M_RUN: begin
                if (fault) begin
                    n.mode = 2'(M_FAULT);
                    n.t    = 16'd0;
                    n.duty = 8'd0;
                end else if (!en) begin
                    n.mode = 2'(M_IDLE);
                    n.t    = 16'd0;
                    n.duty = 8'd0;
                end else begin
                    t     = int'(m.t);
                    d     = int'(m.duty);
                    n.pwm = ((t / p) < d);
                    n.t   = 16'((t + 1) % (255 * p));
                    if (n.t == 16'd0) begin
                        n.ps   = 1'b1;
                        n.duty = 8'(slew_to(int'(m.shadow), d, s));
                    end
                end
            end
            default: begin
                if (fault_clr && !fault) n.mode = 2'(M_IDLE);
            end
        endcase
        n.flt = (n.mode == 2'(M_FAULT));
        if (duty_valid) n.shadow = duty_in;
        return n;
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, n_cyc, obs, exp);
        end
    endtask

    // One clock: advance both models, then compare every output.
    task automatic step();
        mdl_t na;
        mdl_t nb;
        na = mstep(ma, P_A, S_A);
        nb = mstep(mb, P_B, S_B);
        @(posedge clk);
        #1;
        n_cyc++;
        ma = na;
        mb = nb;
        check("A.pwm_out",      {8'd0, a_pwm}, {8'd0, ma.pwm});
        check("A.period_start", {8'd0, a_ps},  {8'd0, ma.ps});
        check("A.duty_applied", {1'b0, a_duty}, {1'b0, ma.duty});
        check("A.faulted",      {8'd0, a_flt}, {8'd0, ma.flt});
        check("B.pwm_out",      {8'd0, b_pwm}, {8'd0, mb.pwm});
        check("B.period_start", {8'd0, b_ps},  {8'd0, mb.ps});
        check("B.duty_applied", {1'b0, b_duty}, {1'b0, mb.duty});
        check("B.faulted",      {8'd0, b_flt}, {8'd0, mb.flt});
    endtask

    // Step until the chosen instance strobes period_start (bounded).
    task automatic wait_ps(input bit on_b);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((((on_b ? b_ps : a_ps)) !== 1'b1) && (k < 2000));
        check(on_b ? "B.ps_wait" : "A.ps_wait", {8'd0, (on_b ? b_ps : a_ps)}, 9'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst.A.pwm",  {8'd0, a_pwm}, 9'd0);
        check("rst.A.duty", {1'b0, a_duty}, 9'd0);
        check("rst.B.flt",  {8'd0, b_flt}, 9'd0);

        // Duty 64, PRESCALE=1: 64 high cycles per 255, strobes 255 apart
        rst = 1'b0;
        duty_in = 8'd64;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        step();
        check("idle.A.ps", {8'd0, a_ps}, 9'd0);
        en = 1'b1;
        step();
        check("enter.A.ps",   {8'd0, a_ps}, 9'd1);
        check("enter.A.duty", {1'b0, a_duty}, 9'd64);
        check("enter.B.duty", {1'b0, b_duty}, 9'd16);
        hi = 0;
        nps = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i < 255) begin
                hi += int'(a_pwm);
                nps += int'(a_ps);
            end
        end
        check("A.high_time",    9'(hi), 9'd64);
        check("A.ps_early",     9'(nps), 9'd0);
        check("A.ps_spacing",   {8'd0, a_ps}, 9'd1);

        // Duty 255 held for 3 periods: never low
        duty_in = 8'd255;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        wait_ps(1'b0);
        lo = 0;
        for (int i = 0; i < 765; i++) begin
            step();
            lo += int'(!a_pwm);
        end
        check("A.duty255_low", 9'(lo), 9'd0);

        // Duty 0 held for 3 periods: never high
        duty_in = 8'd0;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        wait_ps(1'b0);
        hi = 0;
        for (int i = 0; i < 765; i++) begin
            step();
            hi += int'(a_pwm);
        end
        check("A.duty0_high", 9'(hi), 9'd0);

        // Slew 16 on B: 0 -> 100 in steps
        rst = 1'b1;
        en = 1'b0;
        step();
        rst = 1'b0;
        duty_in = 8'd100;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        en = 1'b1;
        step();
        check("slew.B.ps0",   {8'd0, b_ps}, 9'd1);
        check("slew.B.duty0", {1'b0, b_duty}, 9'(slew_exp[0]));
        check("slew.A.duty0", {1'b0, a_duty}, 9'd100);
        for (int k = 1; k < 7; k++) begin
            wait_ps(1'b1);
            check("slew.B.duty", {1'b0, b_duty}, 9'(slew_exp[k]));
        end

        // duty_valid coincident with wrap uses the old shadow
        duty_in = 8'd50;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        wait_ps(1'b0);
        check("wrapdv.A.duty50", {1'b0, a_duty}, 9'd50);
        for (int i = 0; i < 254; i++) step();
        duty_in = 8'd200;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        check("wrapdv.A.ps",      {8'd0, a_ps}, 9'd1);
        check("wrapdv.A.keep50",  {1'b0, a_duty}, 9'd50);
        wait_ps(1'b0);
        check("wrapdv.A.duty200", {1'b0, a_duty}, 9'd200);

        // Fault mid-period at duty 128
        duty_in = 8'd128;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        wait_ps(1'b0);
        for (int i = 0; i < 50; i++) step();
        check("fault.A.pre_pwm", {8'd0, a_pwm}, 9'd1);
        fault = 1'b1;
        step();
        check("fault.A.pwm",  {8'd0, a_pwm}, 9'd0);
        check("fault.A.flt",  {8'd0, a_flt}, 9'd1);
        check("fault.A.duty", {1'b0, a_duty}, 9'd0);
        fault_clr = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("fault.clr_ignored", {8'd0, a_flt}, 9'd1);
        fault = 1'b0;
        step();
        check("fault.release_flt", {8'd0, a_flt}, 9'd0);
        check("fault.release_ps",  {8'd0, a_ps}, 9'd0);
        fault_clr = 1'b0;
        step();
        check("fault.restart_ps",   {8'd0, a_ps}, 9'd1);
        check("fault.restart_duty", {1'b0, a_duty}, 9'd128);

        // Reset mid-period with en held high
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        step();
        check("rstrun.A.pwm",  {8'd0, a_pwm}, 9'd0);
        check("rstrun.A.ps",   {8'd0, a_ps}, 9'd0);
        check("rstrun.A.duty", {1'b0, a_duty}, 9'd0);
        check("rstrun.B.duty", {1'b0, b_duty}, 9'd0);
        step();
        check("rstrun.hold.A.ps", {8'd0, a_ps}, 9'd0);
        rst = 1'b0;
        step();
        check("rstrun.exit.A.ps", {8'd0, a_ps}, 9'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 8000; i++) begin
            rst        = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 999) < 3) en = ~en;
            duty_valid = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 3))
                0:       duty_in = 8'd0;
                1:       duty_in = 8'd255;
                default: duty_in = 8'($urandom_range(0, 255));
            endcase
            fault      = ($urandom_range(0, 999) < 2);
            fault_clr  = ($urandom_range(0, 99) < 20);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_pwm_generator
`default_nettype wire
